// File: rtl/ddr_port0_writer.sv
// Purpose: packs a raster pixel stream into MCB write bursts, one command per burst, never crossing a line.
// Latency: a command issues one cycle after the last word of its burst (more if cmd_full is held).
// Backpressure: pix_ready drops on wr_full, after a full burst, and throughout command issue and advance.
module ddr_port0_writer #(
  parameter int unsigned MAX_BURST  = 64,
  parameter logic [29:0] BASE1_ADDR = 30'd5242880
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_calib_done,
  input  logic [10:0] x_size,
  input  logic [10:0] y_size,
  input  logic        base_selector,
  input  logic        frame_start,
  input  logic [31:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_mask,
  output logic        wr_en,
  input  logic        wr_full,
  input  logic [6:0]  wr_count,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  output logic        cmd_en,
  input  logic        cmd_full,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {IDLE, WAIT_FRAME, FILL, CMD, ADVANCE} state_t;

  localparam logic [10:0] MAX_BURST_W = 11'(MAX_BURST);

  state_t      state, state_nxt;
  logic [1:0]  calib_sync;
  logic        calib_ok;
  logic [10:0] x_lat, y_lat, x_ptr, y_ptr, word_cnt;
  logic [29:0] base_lat;
  logic [10:0] remain, burst_len;
  logic [10:0] x_adv, y_adv;
  logic        line_end, frame_end, zero_frame, accept;
  logic [29:0] pix_index;
  logic        unused_count;

  // Fill level is not needed: acceptance is gated by wr_full alone.
  assign unused_count = ^wr_count;

  assign calib_ok   = calib_sync[1];
  assign remain     = x_lat - x_ptr;
  assign burst_len  = (remain > MAX_BURST_W) ? MAX_BURST_W : remain;
  assign x_adv      = x_ptr + burst_len;
  assign y_adv      = y_ptr + 11'd1;
  assign line_end   = (x_adv == x_lat);
  assign frame_end  = line_end && (y_adv == y_lat);
  assign zero_frame = (x_size == 11'd0) || (y_size == 11'd0);
  assign pix_index  = 30'(y_ptr) * 30'(x_lat) + 30'(x_ptr);

  assign accept  = pix_valid & pix_ready;
  assign wr_en   = accept;
  assign wr_data = pix_data;
  assign wr_mask = 4'b0000;

  // Two-flop synchroniser for the asynchronous calibration level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) calib_sync <= 2'b00;
    else        calib_sync <= {calib_sync[0], mem_calib_done};
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode plus the combinational handshake and command outputs.
  always_comb begin
    state_nxt     = state;
    pix_ready     = 1'b0;
    cmd_en        = 1'b0;
    cmd_instr     = 3'b000;
    cmd_bl        = 6'd0;
    cmd_byte_addr = 30'd0;
    case (state)
      IDLE: begin
        if (calib_ok) state_nxt = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (frame_start && !zero_frame) state_nxt = FILL;
      end
      FILL: begin
        pix_ready = !wr_full && (word_cnt < burst_len);
        if (accept && (word_cnt + 11'd1 == burst_len)) state_nxt = CMD;
      end
      CMD: begin
        if (!cmd_full) begin
          cmd_en        = 1'b1;
          cmd_bl        = 6'(burst_len - 11'd1);
          cmd_byte_addr = base_lat + {pix_index[27:0], 2'b00};
          state_nxt     = ADVANCE;
        end
      end
      ADVANCE: begin
        state_nxt = frame_end ? WAIT_FRAME : FILL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame geometry latch, raster pointers, burst word count and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_lat      <= 11'd0;
      y_lat      <= 11'd0;
      base_lat   <= 30'd0;
      x_ptr      <= 11'd0;
      y_ptr      <= 11'd0;
      word_cnt   <= 11'd0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        WAIT_FRAME: begin
          if (frame_start) begin
            x_lat    <= x_size;
            y_lat    <= y_size;
            base_lat <= base_selector ? BASE1_ADDR : 30'd0;
            x_ptr    <= 11'd0;
            y_ptr    <= 11'd0;
            word_cnt <= 11'd0;
            if (zero_frame) frame_done <= 1'b1;
            else            busy       <= 1'b1;
          end
        end
        FILL: begin
          if (accept) word_cnt <= word_cnt + 11'd1;
        end
        ADVANCE: begin
          word_cnt <= 11'd0;
          if (line_end) begin
            x_ptr <= 11'd0;
            y_ptr <= y_adv;
          end else begin
            x_ptr <= x_adv;
          end
          if (frame_end) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_port0_writer.sv
// Purpose: randomized scoreboard bench for ddr_port0_writer against a per-frame burst model.
// Latency: expected words/commands are queued at frame setup and popped as the DUT presents them.
// Backpressure: random and directed wr_full/cmd_full, random pix_valid gaps.
module tb_ddr_port0_writer;

  typedef struct packed {
    logic [5:0]  bl;
    logic [29:0] addr;
  } cmd_t;

  logic        clk;
  logic        reset;
  logic        mem_calib_done;
  logic [10:0] x_size, y_size;
  logic        base_selector;
  logic        frame_start;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        wr_en;
  logic        wr_full;
  logic [6:0]  wr_count;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        cmd_en;
  logic        cmd_full;
  logic        busy;
  logic        frame_done;

  int          errors;
  int          checks;
  int          done_cnt;
  int          words_since_cmd;
  logic [31:0] pix_q[$];
  logic [31:0] exp_word[$];
  cmd_t        exp_cmd[$];
  logic [31:0] mon_w;
  cmd_t        mon_c;

  ddr_port0_writer dut (
    .clk(clk), .reset(reset), .mem_calib_done(mem_calib_done),
    .x_size(x_size), .y_size(y_size), .base_selector(base_selector),
    .frame_start(frame_start), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .wr_data(wr_data), .wr_mask(wr_mask), .wr_en(wr_en),
    .wr_full(wr_full), .wr_count(wr_count), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
    .cmd_byte_addr(cmd_byte_addr), .cmd_en(cmd_en), .cmd_full(cmd_full),
    .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endfunction

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      words_since_cmd = 0;
    end else begin
      if (wr_en) begin
        if (exp_word.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word got=%h exp=none", wr_data);
        end else begin
          mon_w = exp_word.pop_front();
          chk("wr_data", longint'(wr_data), longint'(mon_w));
        end
        chk("wr_mask", longint'(wr_mask), 0);
        words_since_cmd++;
      end
      if (cmd_en) begin
        if (exp_cmd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cmd got addr=%0d bl=%0d exp=none", cmd_byte_addr, cmd_bl);
        end else begin
          mon_c = exp_cmd.pop_front();
          chk("cmd_addr", longint'(cmd_byte_addr), longint'(mon_c.addr));
          chk("cmd_bl", longint'(cmd_bl), longint'(mon_c.bl));
          chk("cmd_instr", longint'(cmd_instr), 0);
          chk("burst_words_before_cmd", longint'(words_since_cmd), longint'(mon_c.bl) + 1);
        end
        words_since_cmd = 0;
      end
      if (wr_full) chk("ready_under_wr_full", longint'(pix_ready), 0);
      if (cmd_full) chk("cmd_en_under_cmd_full", longint'(cmd_en), 0);
      if (frame_done) done_cnt++;
    end
  end

  // Reference model: one command per MAX_BURST chunk of each line, tail chunk short.
  task automatic setup_frame(input int x, input int y, input bit sel, output int d0);
    int  n;
    longint base;
    cmd_t c;
    base = sel ? 64'd5242880 : 64'd0;
    pix_q.delete();
    for (int yy = 0; yy < y; yy++) begin
      for (int xx = 0; xx < x; xx += 64) begin
        n = (x - xx < 64) ? (x - xx) : 64;
        c.bl   = 6'(n - 1);
        c.addr = 30'(base + longint'(yy * x + xx) * 4);
        exp_cmd.push_back(c);
      end
    end
    for (int i = 0; i < x * y; i++) begin
      pix_q.push_back($urandom);
      exp_word.push_back(pix_q[i]);
    end
    d0 = done_cnt;
    x_size = 11'(x); y_size = 11'(y); base_selector = sel; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    chk("busy_set", longint'(busy), 1);
  endtask

  task automatic stream(input int start, input int cnt, input bit rnd);
    int idx;
    int budget;
    bit hs;
    idx = start;
    budget = cnt * 12 + 200;
    while (idx < start + cnt) begin
      pix_data  = pix_q[idx];
      pix_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rnd) begin
        wr_full       = ($urandom_range(0, 4) == 0);
        cmd_full      = ($urandom_range(0, 3) == 0);
        base_selector = 1'($urandom_range(0, 1));
        x_size        = 11'($urandom_range(0, 2047));
        y_size        = 11'($urandom_range(0, 2047));
        frame_start   = ($urandom_range(0, 15) == 0);
      end
      @(negedge clk);
      hs = pix_valid & pix_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      budget--;
      if (budget == 0) begin
        checks++; errors++;
        $display("FAIL stream_timeout got idx=%0d exp=%0d", idx, start + cnt);
        break;
      end
    end
    pix_valid = 1'b0; frame_start = 1'b0; wr_full = 1'b0; cmd_full = 1'b0;
  endtask

  task automatic finish_frame(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("frame_done_seen", longint'(done_cnt > d0), 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("frame_done_pulses", longint'(done_cnt - d0), 1);
    chk("busy_clear", longint'(busy), 0);
    chk("cmds_left", longint'(exp_cmd.size()), 0);
    chk("words_left", longint'(exp_word.size()), 0);
  endtask

  task automatic run_frame(input int x, input int y, input bit sel);
    int d0;
    setup_frame(x, y, sel, d0);
    stream(0, x * y, 1'b1);
    finish_frame(d0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    errors = 0; checks = 0; done_cnt = 0; words_since_cmd = 0;
    reset = 1'b0; mem_calib_done = 1'b0; x_size = 11'd0; y_size = 11'd0;
    base_selector = 1'b0; frame_start = 1'b0; pix_data = 32'd0; pix_valid = 1'b1;
    wr_full = 1'b0; wr_count = 7'd0; cmd_full = 1'b0;

    // Reset state
    #3;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_frame_done", longint'(frame_done), 0);
    chk("rst_pix_ready", longint'(pix_ready), 0);
    chk("rst_wr_en", longint'(wr_en), 0);
    chk("rst_cmd_en", longint'(cmd_en), 0);
    @(posedge clk); #1;
    reset = 1'b1; pix_valid = 1'b0;

    // frame_start before calibration is ignored
    x_size = 11'd10; y_size = 11'd1; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("precal_busy", longint'(busy), 0);
      @(posedge clk); #1;
    end
    mem_calib_done = 1'b1;
    repeat (5) begin @(posedge clk); #1; end

    // Zero-sized frames finish immediately
    for (int k = 0; k < 2; k++) begin
      x_size = (k == 0) ? 11'd0 : 11'd7;
      y_size = (k == 0) ? 11'd5 : 11'd0;
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      chk("zero_frame_done", longint'(frame_done), 1);
      chk("zero_busy", longint'(busy), 0);
      @(posedge clk); #1;
      chk("zero_frame_done_drop", longint'(frame_done), 0);
    end

    // Directed wr_full / cmd_full stall on a 100x1 line (bursts of 64 then 36)
    setup_frame(100, 1, 1'b0, d0);
    stream(0, 20, 1'b0);
    wr_full = 1'b1; pix_valid = 1'b1; pix_data = pix_q[20];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_wr_ready", longint'(pix_ready), 0);
      chk("stall_wr_en", longint'(wr_en), 0);
      @(posedge clk); #1;
    end
    wr_full = 1'b0;
    stream(20, 44, 1'b0);
    cmd_full = 1'b1; pix_valid = 1'b1; pix_data = pix_q[64];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_cmd_ready", longint'(pix_ready), 0);
      chk("stall_cmd_en", longint'(cmd_en), 0);
      @(posedge clk); #1;
    end
    cmd_full = 1'b0;
    stream(64, 36, 1'b0);
    finish_frame(d0);

    // Large-line frames (shortened heights) and edge widths
    run_frame(640, 4, 1'b0);
    run_frame(800, 3, 1'b0);
    run_frame(1024, 2, 1'b1);
    run_frame(64, 1, 1'b0);
    run_frame(65, 2, 1'b1);
    run_frame(1, 3, 1'b0);
    for (int k = 0; k < 6; k++)
      run_frame($urandom_range(1, 200), $urandom_range(1, 4), 1'($urandom_range(0, 1)));

    // Reset mid-frame after 100 words of 640x480
    setup_frame(640, 480, 1'b0, d0);
    stream(0, 100, 1'b1);
    pix_valid = 1'b1;
    chk("pre_reset_busy", longint'(busy), 1);
    reset = 1'b0;
    #1;
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_pix_ready", longint'(pix_ready), 0);
    chk("midrst_wr_en", longint'(wr_en), 0);
    chk("midrst_cmd_en", longint'(cmd_en), 0);
    chk("midrst_cmd_addr", longint'(cmd_byte_addr), 0);
    chk("midrst_cmd_bl", longint'(cmd_bl), 0);
    chk("midrst_frame_done", longint'(frame_done), 0);
    exp_cmd.delete(); exp_word.delete();
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    x_size = 11'd8; y_size = 11'd1; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("postrst_busy", longint'(busy), 0);
      chk("postrst_pix_ready", longint'(pix_ready), 0);
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    run_frame(64, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
